// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// COUNTDOWN_PRESCALER_EN (see countdown_timer.sv) selects the prescaled build.
package countdown_pkg;

  localparam int DEFAULT_WIDTH        = 64;
  localparam int DEFAULT_PRESCALE_DIV = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } countdown_state_t;

  // Bits needed to hold 0..div-1; never less than one bit.
  function automatic int prescale_w(input int div);
    int w;
    w = 1;
    while (w < 31 && (1 << w) < div) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/countdown_prescaler.sv
// Tick divider: asserts TICK on every DIV-th qualified EN cycle.
// CLR takes priority over EN and returns the count to zero.
module countdown_prescaler
  import countdown_pkg::*;
#(
  parameter int DIV = DEFAULT_PRESCALE_DIV,
  parameter int W   = prescale_w(DEFAULT_PRESCALE_DIV)
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  logic [W-1:0] cnt;
  logic         at_top;

  assign at_top = (cnt == W'(DIV - 1));

  // Count qualified EN cycles, wrapping after DIV-1.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= at_top ? '0 : cnt + W'(1);
    end
  end

  // The wrap cycle is the decrement opportunity for the timer.
  always_comb begin
    TICK = EN && at_top;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with one-cycle expiry pulse,
// one-shot or auto-reload operation.
// Optional: define COUNTDOWN_PRESCALER_EN to decrement only every
// PRESCALE_DIV qualified EN cycles.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | loaded or expired, waiting for START
// RUNNING | decrementing on each tick
// PAUSED  | stopped by STOP, VALUE held, START resumes
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             START,
  input  logic             STOP,
  input  logic             PERIODIC,
  output logic [WIDTH-1:0] VALUE,
  output logic             EXPIRED,
  output logic             BUSY
);

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 65535) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE_DIV must be in 2..65535");
  end

  countdown_state_t state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  logic tick;
  logic running;
  logic start_ok;
  logic expire_evt;

  // LOAD outranks STOP, and STOP outranks START; these decodes bake that in.
  assign running    = (state_q == RUNNING);
  assign start_ok   = !LOAD && !STOP && START && !running && (value_q != '0);
  assign expire_evt = !LOAD && !STOP && running && tick && (value_q == WIDTH'(1));

`ifdef COUNTDOWN_PRESCALER_EN
  localparam int PRESCALE_W = prescale_w(PRESCALE_DIV);

  logic pre_en;
  logic pre_clr;

  // A STOP or LOAD cycle is not a counting cycle, so it does not advance the prescaler.
  assign pre_en  = EN && running && !LOAD && !STOP;
  assign pre_clr = LOAD || start_ok || expire_evt;

  countdown_prescaler #(
    .DIV (PRESCALE_DIV),
    .W   (PRESCALE_W)
  ) u_prescaler (
    .CLK  (CLK),
    .RSTN (RSTN),
    .CLR  (pre_clr),
    .EN   (pre_en),
    .TICK (tick)
  );
`else
  assign tick = EN;
`endif

  // State and datapath registers; reset overrides every input.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Next-state and next-count decode in command priority order.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (LOAD) begin
      value_d  = LOAD_VALUE;
      reload_d = LOAD_VALUE;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        RUNNING: begin
          if (STOP) begin
            state_d = PAUSED;
          end else if (value_q == '0) begin
            // Only reachable with a zero reload; park safely rather than wrap.
            state_d = IDLE;
          end else if (tick) begin
            if (value_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (PERIODIC) begin
                value_d = reload_q;
              end else begin
                value_d = '0;
                state_d = IDLE;
              end
            end else begin
              value_d = value_q - WIDTH'(1);
            end
          end
        end
        IDLE, PAUSED: begin
          if (start_ok) begin
            state_d = RUNNING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    VALUE   = value_q;
    EXPIRED = expired_q;
    BUSY    = (state_q == RUNNING);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Default build checks the unprescaled behaviour; with COUNTDOWN_PRESCALER_EN
// defined it checks the divide-by-4 prescaled behaviour instead.
module tb_countdown_timer;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         EN;
  logic         LOAD;
  logic [W-1:0] LOAD_VALUE;
  logic         START;
  logic         STOP;
  logic         PERIODIC;
  logic [W-1:0] VALUE;
  logic         EXPIRED;
  logic         BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer #(
    .WIDTH        (W),
    .PRESCALE_DIV (4)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .EN         (EN),
    .LOAD       (LOAD),
    .LOAD_VALUE (LOAD_VALUE),
    .START      (START),
    .STOP       (STOP),
    .PERIODIC   (PERIODIC),
    .VALUE      (VALUE),
    .EXPIRED    (EXPIRED),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input bit e, input bit b);
    chk({tag, ".value"},   64'(VALUE),   64'(v));
    chk({tag, ".expired"}, 64'(EXPIRED), 64'(e));
    chk({tag, ".busy"},    64'(BUSY),    64'(b));
  endtask

  task automatic pulse_load(input int v);
    LOAD_VALUE = W'(v);
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  initial begin
    int exp_p[9];
    int pulses;
    int cyc;

    RSTN = 1'b0; EN = 1'b0; LOAD = 1'b0; LOAD_VALUE = '0;
    START = 1'b0; STOP = 1'b0; PERIODIC = 1'b0;
    step(); step();
    chk_out("reset", 0, 1'b0, 1'b0);
    RSTN = 1'b1;
    step();

`ifdef COUNTDOWN_PRESCALER_EN
    // Prescaled: LOAD 2 with divide-by-4 expires after 8 EN cycles.
    EN = 1'b1;
    pulse_load(2);
    chk_out("pre_load", 2, 1'b0, 1'b0);
    pulse_start();
    chk_out("pre_start", 2, 1'b0, 1'b1);
    step(); step(); step();
    chk_out("pre_3en", 2, 1'b0, 1'b1);
    step();
    chk_out("pre_4en", 1, 1'b0, 1'b1);
    cyc = 4;
    while (!EXPIRED && cyc < 40) begin
      step();
      cyc++;
    end
    chk("pre_expiry_cycles", 64'(cyc), 64'd8);
    chk_out("pre_expired", 0, 1'b1, 1'b0);

    // Reset mid-count.
    pulse_load(3);
    pulse_start();
    step(); step();
    RSTN = 1'b0;
    step();
    chk_out("pre_rst_mid", 0, 1'b0, 1'b0);
    RSTN = 1'b1;
    EN = 1'b0;
    step();
`else
    // One-shot 5 -> 0.
    EN = 1'b1;
    pulse_load(5);
    chk_out("os_load", 5, 1'b0, 1'b0);
    pulse_start();
    chk_out("os_start", 5, 1'b0, 1'b1);
    for (int v = 4; v >= 1; v--) begin
      step();
      chk_out($sformatf("os_v%0d", v), v, 1'b0, 1'b1);
    end
    step();
    chk_out("os_expire", 0, 1'b1, 1'b0);
    step();
    chk_out("os_after", 0, 1'b0, 1'b0);

    // Periodic 3 for 9 EN cycles.
    PERIODIC = 1'b1;
    pulse_load(3);
    pulse_start();
    chk_out("per_start", 3, 1'b0, 1'b1);
    exp_p = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (EXPIRED) pulses++;
      chk_out($sformatf("per_c%0d", i), exp_p[i], (exp_p[i] == 3), 1'b1);
    end
    chk("per_pulse_count", 64'(pulses), 64'd3);
    PERIODIC = 1'b0;
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("per_stop", 3, 1'b0, 1'b0);

    // Pause and resume.
    pulse_load(10);
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk_out("pr_4en", 6, 1'b0, 1'b1);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("pr_stop", 6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_out("pr_paused", 6, 1'b0, 1'b0);
    pulse_start();
    chk_out("pr_resume", 6, 1'b0, 1'b1);
    step();
    chk_out("pr_v5", 5, 1'b0, 1'b1);
    EN = 1'b0;
    step();
    chk_out("pr_en0_hold", 5, 1'b0, 1'b1);
    EN = 1'b1;
    step();
    chk_out("pr_v4", 4, 1'b0, 1'b1);

    // START with VALUE==0 after reset is ignored.
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    pulse_start();
    chk_out("start_zero", 0, 1'b0, 1'b0);

    // START+STOP together from IDLE: STOP wins.
    pulse_load(4);
    START = 1'b1;
    STOP = 1'b1;
    step();
    START = 1'b0;
    STOP = 1'b0;
    chk_out("start_stop", 4, 1'b0, 1'b0);

    // LOAD on the expiry cycle wins.
    pulse_load(2);
    pulse_start();
    step();
    chk_out("ld_exp_pre", 1, 1'b0, 1'b1);
    pulse_load(7);
    chk_out("ld_exp", 7, 1'b0, 1'b0);
    step();
    chk_out("ld_exp_after", 7, 1'b0, 1'b0);

    // STOP on the expiry cycle wins; resume then expires.
    pulse_load(2);
    pulse_start();
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("stop_exp", 1, 1'b0, 1'b0);
    pulse_start();
    chk_out("stop_exp_resume", 1, 1'b0, 1'b1);
    step();
    chk_out("stop_exp_fire", 0, 1'b1, 1'b0);

    // Periodic with reload 1: pulse on every EN cycle.
    PERIODIC = 1'b1;
    pulse_load(1);
    pulse_start();
    step();
    chk_out("rl1_a", 1, 1'b1, 1'b1);
    step();
    chk_out("rl1_b", 1, 1'b1, 1'b1);
    EN = 1'b0;
    step();
    chk_out("rl1_en0", 1, 1'b0, 1'b1);
    EN = 1'b1;
    PERIODIC = 1'b0;

    // Reset mid-count.
    pulse_load(10);
    pulse_start();
    step(); step();
    chk_out("rst_mid_pre", 8, 1'b0, 1'b1);
    RSTN = 1'b0;
    step();
    chk_out("rst_mid", 0, 1'b0, 1'b0);
    RSTN = 1'b1;
    EN = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, pausable down-counter with terminal-count detection; the decrementing counterpart of the free-running up-counter in the library.
- Software or control logic loads a count, starts it, and receives a one-cycle EXPIRED pulse when the count reaches zero.
- Operates in one-shot or periodic (auto-reload) mode.
- Used for timeouts, watchdogs and periodic event generation.

Parameters:
- WIDTH, 64, counter and load-value width in bits.
- PRESCALE_DIV, 16, ticks per decrement. Used only when COUNTDOWN_PRESCALER_EN is defined; legal range 2..65535.

Ports:
- CLK  input  1  clock.
- RSTN  input  1  synchronous reset, active-low.
- EN  input  1  tick qualifier; the counter decrements only on cycles where EN=1 while RUNNING.
- LOAD  input  1  pulse: capture LOAD_VALUE into the counter and reload register.
- LOAD_VALUE  input  WIDTH  count to load.
- START  input  1  pulse: begin or resume counting.
- STOP  input  1  pulse: pause counting.
- PERIODIC  input  1  1 = auto-reload on expiry; 0 = one-shot. Sampled at the expiry cycle.
- VALUE  output  WIDTH  current count.
- EXPIRED  output  1  one-cycle pulse on terminal count.
- BUSY  output  1  high while in RUNNING.

Behaviour:
- All outputs and state are registered; the block has no combinational paths from inputs to outputs.
- Reset (RSTN=0 at a CLK edge): VALUE=0, reload register=0, state=IDLE, EXPIRED=0, BUSY=0. Reset overrides every input.
- States: IDLE, RUNNING, PAUSED, encoded as an enum.
- Command priority, highest first: LOAD > STOP > START.
  - LOAD in any state: VALUE and reload register take LOAD_VALUE next cycle; state goes to IDLE; no EXPIRED pulse.
  - STOP in RUNNING goes to PAUSED with VALUE held. STOP in IDLE or PAUSED is ignored.
  - START in IDLE or PAUSED goes to RUNNING next cycle, provided VALUE != 0. START with VALUE==0 is ignored; state is unchanged and no pulse is issued. START in RUNNING is ignored.
  - START and STOP asserted in the same cycle: STOP wins.
- RUNNING with EN=1 and VALUE>1: VALUE decrements by 1.
- RUNNING with EN=1 and VALUE==1 (expiry cycle): EXPIRED=1 for exactly the next cycle.
  - PERIODIC=1: VALUE becomes the reload register and the state stays RUNNING.
  - PERIODIC=0: VALUE becomes 0 and the state becomes IDLE.
- RUNNING with EN=0: VALUE holds.
- Latency: the first decrement happens on the first EN=1 cycle after the state registers RUNNING, i.e. one cycle after START at the earliest.
- Periodic with reload=1: EXPIRED is high on every EN=1 cycle.
- LOAD on the expiry cycle: LOAD wins; no EXPIRED pulse.
- STOP on the expiry cycle: STOP wins; the decrement is not applied.
- Unsigned arithmetic throughout. VALUE never wraps below 0, and no underflow flag is needed.
- BUSY equals (state==RUNNING) and comes straight from the state register.

Optional Feature:
- Macro COUNTDOWN_PRESCALER_EN.
- Defined:
  - An internal prescaler counts EN=1 cycles while RUNNING. A decrement occurs only when the prescaler reaches PRESCALE_DIV-1; the prescaler then wraps to 0.
  - The prescaler clears on reset, LOAD, START and expiry. It holds in PAUSED.
- Not defined: every EN=1 cycle in RUNNING decrements, and the PRESCALE_DIV parameter is unused.

Decomposition:
- Package countdown_pkg holds:
  - the state enum type countdown_state_t (IDLE, RUNNING, PAUSED);
  - localparam PRESCALE_W = $clog2(PRESCALE_DIV) expressed as a function;
  - a default WIDTH constant.
- One natural sub-module, countdown_prescaler (inputs CLK, RSTN, CLR, EN; output TICK). It is instantiated only under COUNTDOWN_PRESCALER_EN. Otherwise TICK=EN.

Test Plan:
- Reset, then LOAD_VALUE=5, LOAD, START, EN=1 continuous, PERIODIC=0 -> VALUE 5,4,3,2,1,0; EXPIRED high exactly once, in the same cycle as VALUE=0; BUSY drops with it; state ends IDLE.
- LOAD 3, PERIODIC=1, START, EN=1 for 9 cycles -> EXPIRED pulses every 3rd cycle (3 pulses); VALUE sequence 3,2,1,3,2,1...
- LOAD 10, START, 4 EN cycles, STOP, 5 idle cycles, START -> VALUE holds at 6 through PAUSED; resumes 5,4,...; BUSY low while paused.
- START with VALUE=0 after reset -> no state change, BUSY=0, EXPIRED=0. Same-cycle START+STOP from IDLE with VALUE=4 -> stays IDLE.
- LOAD 2, START, then assert LOAD(7) on the expiry cycle -> no EXPIRED; VALUE=7; state IDLE.
- With COUNTDOWN_PRESCALER_EN, PRESCALE_DIV=4, LOAD 2, START, EN=1 -> EXPIRED after 8 EN cycles. Also: RSTN=0 mid-count -> VALUE=0, BUSY=0 next cycle.
